// File: rtl/clock_pkg.sv
// Package: clock_pkg
// Shared widths, limits and the hour:minute type used by the alarm clock.
// hm_add_min() adds a signed minute offset to an hour:minute value and
// wraps the result around a 24-hour day.
package clock_pkg;

    localparam int HOUR_W       = 5;
    localparam int MIN_W        = 6;
    localparam int SEC_W        = 6;
    localparam int MAX_HOUR     = 23;
    localparam int MAX_MIN      = 59;
    localparam int MINS_PER_DAY = (MAX_HOUR + 1) * (MAX_MIN + 1);

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
    } hm_t;

    function automatic hm_t hm_add_min(hm_t t, int add_min);
        int  total;
        hm_t r;
        total = (int'(t.hour) * (MAX_MIN + 1) + int'(t.min) + add_min) % MINS_PER_DAY;
        if (total < 0) begin
            total = total + MINS_PER_DAY;
        end
        r.hour = HOUR_W'(total / (MAX_MIN + 1));
        r.min  = MIN_W'(total % (MAX_MIN + 1));
        return r;
    endfunction

endpackage

// File: rtl/clock_tick_gen.sv
// Module: clock_tick_gen
// Seconds prescaler. Counts enabled clk cycles 0..TICKS_PER_SEC-1 and flags
// the wrap cycle, which is the cycle in which the time advances.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous reset, active HIGH
//   ena    in  count enable; 0 holds the count
//   clear  in  restart the second (count -> 0, no tick this cycle)
//   tick   out combinational: this enabled cycle completes a second
module clock_tick_gen #(
    parameter int TICKS_PER_SEC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count;

    assign tick = ena && !clear && (count == LAST);

    // NOTE: despite its name, rst_n is active high, hence the posedge in the
    // sensitivity list; state registers use non-blocking assignments so every
    // flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (ena) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// Module: multi_alarm_clock
// 24-hour hh:mm:ss timekeeper with a seconds prescaler, NUM_ALARMS
// programmable alarm slots, acknowledge and snooze. Time keeps running while
// an alarm rings.
// Ports:
//   clk, rst_n                  clock; asynchronous reset, active HIGH
//   ena                         timekeeping enable
//   set_time, set_hours/minutes load h:m (seconds cleared), range checked
//   alm_wr, alm_id, alm_hours,
//   alm_minutes, alm_en         write one alarm slot, range checked
//   ack, snooze                 stop ringing / stop and re-ring later
//   hours, minutes, seconds     current time
//   sec_tick                    1-cycle pulse with each seconds increment
//   alarm, alarm_id             ringing flag and slot of current/last ring
module multi_alarm_clock
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int NUM_ALARMS    = 4,
    parameter int SNOOZE_MIN    = 5,
    parameter int IDW           = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              set_time,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    input  logic              alm_wr,
    input  logic [IDW-1:0]    alm_id,
    input  logic [HOUR_W-1:0] alm_hours,
    input  logic [MIN_W-1:0]  alm_minutes,
    input  logic              alm_en,
    input  logic              ack,
    input  logic              snooze,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic              sec_tick,
    output logic              alarm,
    output logic [IDW-1:0]    alarm_id
);

    logic             tick;
    logic             set_ok;
    logic             wr_ok;
    logic             check;
    logic [SEC_W-1:0] nxt_s;
    hm_t              nxt_hm;
    hm_t              cur_hm;
    hm_t              snz_target;

    hm_t              slot_hm [NUM_ALARMS];
    logic             slot_en [NUM_ALARMS];
    logic             slot_hit;
    logic [IDW-1:0]   slot_hit_id;

    logic             snz_pending;
    hm_t              snz_hm;
    logic [IDW-1:0]   snz_id;
    logic             snz_hit;

    assign set_ok = set_time && (set_hours <= HOUR_W'(MAX_HOUR))
                             && (set_minutes <= MIN_W'(MAX_MIN));
    assign wr_ok  = alm_wr && (alm_hours <= HOUR_W'(MAX_HOUR))
                           && (alm_minutes <= MIN_W'(MAX_MIN))
                           && (int'(alm_id) < NUM_ALARMS);

    // A valid set_time restarts the current second, so it also suppresses
    // the prescaler tick of the same cycle.
    clock_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (set_ok),
        .tick  (tick)
    );

    // Time after one more second.
    // NOTE: every variable written here gets a default first so that no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        nxt_s       = seconds + SEC_W'(1);
        nxt_hm.hour = hours;
        nxt_hm.min  = minutes;
        if (seconds == SEC_W'(MAX_MIN)) begin
            nxt_s = '0;
            if (minutes == MIN_W'(MAX_MIN)) begin
                nxt_hm.min  = '0;
                nxt_hm.hour = (hours == HOUR_W'(MAX_HOUR)) ? '0 : hours + HOUR_W'(1);
            end else begin
                nxt_hm.min = minutes + MIN_W'(1);
            end
        end
    end

    // Priority encoder: scanning downwards lets the lowest matching slot win.
    always_comb begin
        slot_hit    = 1'b0;
        slot_hit_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (slot_en[i] && (slot_hm[i] == nxt_hm)) begin
                slot_hit    = 1'b1;
                slot_hit_id = IDW'(i);
            end
        end
    end

    assign cur_hm     = '{hour: hours, min: minutes};
    assign snz_target = hm_add_min(cur_hm, SNOOZE_MIN);
    // Alarms are evaluated only when the new time lands on hh:mm:00.
    assign check      = tick && (nxt_s == '0);
    assign snz_hit    = snz_pending && (snz_hm == nxt_hm);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hours       <= '0;
            minutes     <= '0;
            seconds     <= '0;
            sec_tick    <= 1'b0;
            alarm       <= 1'b0;
            alarm_id    <= '0;
            snz_pending <= 1'b0;
            snz_hm      <= '0;
            snz_id      <= '0;
            // NOTE: the slot array is reset too, because reset must leave
            // every slot disabled; this keeps it in flops rather than RAM.
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_hm[i] <= '0;
                slot_en[i] <= 1'b0;
            end
        end else begin
            sec_tick <= 1'b0;
            if (set_ok) begin
                hours   <= set_hours;
                minutes <= set_minutes;
                seconds <= '0;
            end else if (tick) begin
                hours    <= nxt_hm.hour;
                minutes  <= nxt_hm.min;
                seconds  <= nxt_s;
                sec_tick <= 1'b1;
            end

            if (wr_ok) begin
                slot_hm[alm_id] <= '{hour: alm_hours, min: alm_minutes};
                slot_en[alm_id] <= alm_en;
            end

            // While ringing, new matches are ignored; ack outranks snooze.
            if (alarm) begin
                if (ack) begin
                    alarm       <= 1'b0;
                    snz_pending <= 1'b0;
                end else if (snooze) begin
                    alarm       <= 1'b0;
                    snz_pending <= 1'b1;
                    snz_hm      <= snz_target;
                    snz_id      <= alarm_id;
                end
            end else if (check) begin
                // A slot match beats the snooze target; the snooze then
                // stays pending.
                if (slot_hit) begin
                    alarm    <= 1'b1;
                    alarm_id <= slot_hit_id;
                end else if (snz_hit) begin
                    alarm       <= 1'b1;
                    alarm_id    <= snz_id;
                    snz_pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Testbench: tb_multi_alarm_clock
// Directed scenarios followed by a randomized phase, all compared against a
// reference model that keeps time as seconds-of-day and alarms as
// minutes-of-day.
module tb_multi_alarm_clock;

    localparam int TPS = 4;
    localparam int NA  = 4;
    localparam int SNZ = 5;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           ena = 1'b0;
    logic           set_time = 1'b0;
    logic [4:0]     set_hours = '0;
    logic [5:0]     set_minutes = '0;
    logic           alm_wr = 1'b0;
    logic [IDW-1:0] alm_id = '0;
    logic [4:0]     alm_hours = '0;
    logic [5:0]     alm_minutes = '0;
    logic           alm_en = 1'b0;
    logic           ack = 1'b0;
    logic           snooze = 1'b0;
    logic [4:0]     hours;
    logic [5:0]     minutes;
    logic [5:0]     seconds;
    logic           sec_tick;
    logic           alarm;
    logic [IDW-1:0] alarm_id;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int tod;            // seconds since midnight
    int pre;            // enabled cycles into the current second
    bit m_tick;
    bit m_alarm;
    int m_id;
    int s_min [NA];     // slot time as minute of day
    bit s_en  [NA];
    bit snz_p;
    int snz_min;
    int snz_id;

    multi_alarm_clock #(
        .TICKS_PER_SEC(TPS),
        .NUM_ALARMS   (NA),
        .SNOOZE_MIN   (SNZ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .set_time    (set_time),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .alm_wr      (alm_wr),
        .alm_id      (alm_id),
        .alm_hours   (alm_hours),
        .alm_minutes (alm_minutes),
        .alm_en      (alm_en),
        .ack         (ack),
        .snooze      (snooze),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
        .sec_tick    (sec_tick),
        .alarm       (alarm),
        .alarm_id    (alarm_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        tod = 0; pre = 0; m_tick = 0; m_alarm = 0; m_id = 0;
        snz_p = 0; snz_min = 0; snz_id = 0;
        for (int i = 0; i < NA; i++) begin
            s_min[i] = 0;
            s_en[i]  = 0;
        end
    endtask

    // One clock edge of behaviour, using the inputs the DUT just sampled.
    task automatic model_update();
        bit set_ok;
        bit tk;
        int old_tod;
        int mod;
        int hit;
        set_ok  = set_time && int'(set_hours) <= 23 && int'(set_minutes) <= 59;
        old_tod = tod;
        tk      = 0;
        if (set_ok) begin
            tod = int'(set_hours) * 3600 + int'(set_minutes) * 60;
            pre = 0;
        end else if (ena) begin
            if (pre == TPS - 1) begin
                pre = 0;
                tk  = 1;
                tod = (tod + 1) % 86400;
            end else begin
                pre++;
            end
        end
        m_tick = tk;
        if (m_alarm) begin
            if (ack) begin
                m_alarm = 0;
                snz_p   = 0;
            end else if (snooze) begin
                m_alarm = 0;
                snz_p   = 1;
                snz_min = (old_tod / 60 + SNZ) % 1440;
                snz_id  = m_id;
            end
        end else if (tk && tod % 60 == 0) begin
            mod = tod / 60;
            hit = -1;
            for (int i = 0; i < NA; i++) begin
                if (hit < 0 && s_en[i] && s_min[i] == mod) hit = i;
            end
            if (hit >= 0) begin
                m_alarm = 1;
                m_id    = hit;
            end else if (snz_p && snz_min == mod) begin
                m_alarm = 1;
                m_id    = snz_id;
                snz_p   = 0;
            end
        end
        if (alm_wr && int'(alm_hours) <= 23 && int'(alm_minutes) <= 59 && int'(alm_id) < NA) begin
            s_min[int'(alm_id)] = int'(alm_hours) * 60 + int'(alm_minutes);
            s_en[int'(alm_id)]  = alm_en;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " hours"},    hours,    tod / 3600);
        chk({tag, " minutes"},  minutes,  (tod / 60) % 60);
        chk({tag, " seconds"},  seconds,  tod % 60);
        chk({tag, " sec_tick"}, sec_tick, m_tick);
        chk({tag, " alarm"},    alarm,    m_alarm);
        chk({tag, " alarm_id"}, alarm_id, m_id);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        chk({tag, " h"}, hours,   h);
        chk({tag, " m"}, minutes, m);
        chk({tag, " s"}, seconds, s);
    endtask

    // Advance one edge; returns 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_reset();
        else       model_update();
        #1;
    endtask

    task automatic run_ticks(input int n, input string tag);
        int got;
        int budget;
        got    = 0;
        budget = n * TPS + 2 * TPS;
        while (got < n && budget > 0) begin
            step();
            check_all(tag);
            if (m_tick) got++;
            budget--;
        end
        chk({tag, " tick budget"}, got, n);
    endtask

    task automatic set_clock(input int h, input int m, input string tag);
        set_time = 1'b1; set_hours = 5'(h); set_minutes = 6'(m);
        step();
        check_all(tag);
        set_time = 1'b0;
    endtask

    task automatic write_slot(input int id, input int h, input int m, input bit en);
        alm_wr = 1'b1; alm_id = IDW'(id); alm_hours = 5'(h); alm_minutes = 6'(m); alm_en = en;
        step();
        check_all("slot_wr");
        alm_wr = 1'b0;
    endtask

    task automatic pulse(input bit a, input bit s, input string tag);
        ack = a; snooze = s;
        step();
        check_all(tag);
        ack = 1'b0; snooze = 1'b0;
    endtask

    initial begin
        model_reset();
        step();
        step();
        check_time("reset", 0, 0, 0);
        chk("reset sec_tick", sec_tick, 0);
        chk("reset alarm", alarm, 0);
        chk("reset alarm_id", alarm_id, 0);
        rst_n = 1'b0;

        // 1. midnight rollover, sec_tick every TPS-th cycle
        set_clock(23, 59, "t1_set");
        ena = 1'b1;
        for (int c = 1; c <= 60 * TPS; c++) begin
            step();
            check_all("t1_run");
            chk("t1 tick cadence", sec_tick, (c % TPS) == 0);
        end
        check_time("t1_end", 0, 0, 0);
        ena = 1'b0;

        // 2. single slot fires on the :00 tick and keeps ringing
        write_slot(2, 7, 30, 1);
        set_clock(7, 29, "t2_set");
        ena = 1'b1;
        run_ticks(60, "t2_run");
        check_time("t2_ring", 7, 30, 0);
        chk("t2 alarm", alarm, 1);
        chk("t2 alarm_id", alarm_id, 2);
        run_ticks(5, "t2_more");
        check_time("t2_more", 7, 30, 5);
        chk("t2 alarm held", alarm, 1);
        ena = 1'b0;
        pulse(1, 0, "t2_ack");
        chk("t2 ack", alarm, 0);

        // 3. tie resolves to lowest slot; the slot fires again the following day
        write_slot(2, 7, 30, 0);
        write_slot(0, 6, 0, 1);
        write_slot(3, 6, 0, 1);
        set_clock(5, 59, "t3_set");
        ena = 1'b1;
        run_ticks(60, "t3_run");
        chk("t3 alarm", alarm, 1);
        chk("t3 alarm_id", alarm_id, 0);
        pulse(1, 0, "t3_ack");
        chk("t3 ack", alarm, 0);
        ena = 1'b0;
        set_clock(5, 59, "t3_nextday");
        ena = 1'b1;
        run_ticks(60, "t3_run2");
        check_time("t3_ring2", 6, 0, 0);
        chk("t3 re-ring", alarm, 1);
        chk("t3 re-ring id", alarm_id, 0);
        ena = 1'b0;
        pulse(1, 0, "t3_ack2");

        // 4. snooze across midnight, then ack+snooze together
        write_slot(0, 6, 0, 0);
        write_slot(3, 6, 0, 0);
        write_slot(1, 23, 58, 1);
        set_clock(23, 57, "t4_set");
        ena = 1'b1;
        run_ticks(70, "t4_run");
        check_time("t4_ring", 23, 58, 10);
        chk("t4 ringing", alarm, 1);
        ena = 1'b0;
        pulse(0, 1, "t4_snooze");
        chk("t4 snoozed", alarm, 0);
        ena = 1'b1;
        run_ticks(290, "t4_wait");
        check_time("t4_snz_ring", 0, 3, 0);
        chk("t4 snooze ring", alarm, 1);
        chk("t4 snooze id", alarm_id, 1);
        ena = 1'b0;
        pulse(1, 1, "t4_ack_snz");
        chk("t4 ack wins", alarm, 0);
        ena = 1'b1;
        run_ticks(300, "t4_quiet");
        chk("t4 no re-ring", alarm, 0);
        ena = 1'b0;

        // 5. out-of-range set ignored; set_time beats a coincident tick
        set_clock(24, 10, "t5_bad_h");
        check_time("t5_bad_h", 0, 8, 0);
        set_clock(10, 60, "t5_bad_m");
        check_time("t5_bad_m", 0, 8, 0);
        ena = 1'b1;
        for (int k = 0; k < TPS && pre != TPS - 1; k++) begin
            step();
            check_all("t5_align");
        end
        set_clock(12, 34, "t5_on_tick");
        check_time("t5_on_tick", 12, 34, 0);
        chk("t5 no sec_tick", sec_tick, 0);
        run_ticks(1, "t5_after");
        ena = 1'b0;

        // 6. asynchronous reset while ringing with a snooze pending
        write_slot(1, 23, 58, 0);
        write_slot(0, 10, 0, 1);
        write_slot(1, 10, 1, 1);
        set_clock(9, 59, "t6_set");
        ena = 1'b1;
        run_ticks(60, "t6_ring0");
        chk("t6 ring0", alarm, 1);
        ena = 1'b0;
        pulse(0, 1, "t6_snooze");
        ena = 1'b1;
        run_ticks(60, "t6_ring1");
        chk("t6 ring1", alarm, 1);
        chk("t6 ring1 id", alarm_id, 1);
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        check_time("t6_async", 0, 0, 0);
        chk("t6 async alarm", alarm, 0);
        chk("t6 async alarm_id", alarm_id, 0);
        chk("t6 async sec_tick", sec_tick, 0);
        ena = 1'b0;
        step();
        rst_n = 1'b0;
        set_clock(9, 59, "t6_post");
        ena = 1'b1;
        run_ticks(360, "t6_quiet");
        check_time("t6_quiet", 10, 5, 0);
        chk("t6 no ring", alarm, 0);

        // Randomized phase
        set_clock(0, 0, "rnd_start");
        for (int c = 0; c < 3000; c++) begin
            ena      = ($urandom % 8) != 0;
            set_time = ($urandom % 200) == 0;
            set_hours   = (($urandom % 10) == 0) ? 5'd24 : 5'($urandom_range(0, 1));
            set_minutes = (($urandom % 10) == 0) ? 6'd60 : 6'($urandom_range(0, 5));
            alm_wr   = ($urandom % 30) == 0;
            alm_id   = IDW'($urandom);
            alm_hours   = (($urandom % 12) == 0) ? 5'd25 : 5'(tod / 3600);
            alm_minutes = (($urandom % 12) == 0) ? 6'd61 : 6'(((tod / 60) + $urandom_range(0, 2)) % 60);
            alm_en   = ($urandom % 4) != 0;
            ack      = ($urandom % 60) == 0;
            snooze   = ($urandom % 40) == 0;
            step();
            check_all("rnd");
        end
        set_time = 1'b0; alm_wr = 1'b0; ack = 1'b0; snooze = 1'b0; ena = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
